// File: rtl/av2_forward_transform_4x4.sv
// Forward 4x4 block transform (DCT / WHT / identity): a row transform applied
// as each residual row arrives, then a column transform, then rows streamed out.
module av2_forward_transform_4x4 #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            tx_type,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DATA_W-1:0]   in_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DATA_W-1:0]   out_row,
  output logic [1:0]            out_row_idx,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUT} state_t;

  localparam int SAT_MAX_I = (1 << (DATA_W - 1)) - 1;
  localparam int SAT_MIN_I = -(1 << (DATA_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_I);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(SAT_MIN_I);

  state_t state_q, state_d;
  logic        en_q;
  logic [1:0]  cnt_q;
  logic [1:0]  idx_q;
  logic [1:0]  tx_q;
  logic signed [ACC_W-1:0]  h_q   [4][4];
  logic signed [DATA_W-1:0] buf_q [4][4];

  logic signed [ACC_W-1:0] row_x [4];
  logic signed [ACC_W-1:0] row_h [4];
  logic signed [ACC_W-1:0] col_y [4][4];
  logic [1:0] cur_type;
  logic       in_hs;
  logic       out_hs;

  // Output k of the 1-D transform selected by t; types 2 and 3 are identity.
  function automatic logic signed [ACC_W-1:0] xform(
    input logic [1:0]              t,
    input logic [1:0]              k,
    input logic signed [ACC_W-1:0] a0,
    input logic signed [ACC_W-1:0] a1,
    input logic signed [ACC_W-1:0] a2,
    input logic signed [ACC_W-1:0] a3
  );
    logic signed [ACC_W-1:0] r;
    r = '0;
    case (t)
      2'd0: begin
        case (k)
          2'd0:    r = a0 + a1 + a2 + a3;
          2'd1:    r = (a0 <<< 1) + a1 - a2 - (a3 <<< 1);
          2'd2:    r = a0 - a1 - a2 + a3;
          default: r = a0 - (a1 <<< 1) + (a2 <<< 1) - a3;
        endcase
      end
      2'd1: begin
        case (k)
          2'd0:    r = a0 + a1 + a2 + a3;
          2'd1:    r = a0 + a1 - a2 - a3;
          2'd2:    r = a0 - a1 - a2 + a3;
          default: r = a0 - a1 + a2 - a3;
        endcase
      end
      default: begin
        case (k)
          2'd0:    r = a0;
          2'd1:    r = a1;
          2'd2:    r = a2;
          default: r = a3;
        endcase
      end
    endcase
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    logic signed [DATA_W-1:0] r;
    if (a > SAT_MAX) begin
      r = SAT_MAX[DATA_W-1:0];
    end else if (a < SAT_MIN) begin
      r = SAT_MIN[DATA_W-1:0];
    end else begin
      r = a[DATA_W-1:0];
    end
    return r;
  endfunction

  assign in_ready    = en_q && (state_q == IDLE || state_q == LOAD);
  assign out_valid   = (state_q == OUT);
  assign out_row_idx = idx_q;
  assign out_last    = out_valid && (idx_q == 2'd3);
  assign busy        = (state_q != IDLE);
  assign in_hs       = in_valid && in_ready;
  assign out_hs      = out_valid && out_ready;

  // The first row must use the live tx_type since it is latched on that same edge.
  assign cur_type = (state_q == IDLE) ? tx_type : tx_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign row_x[gi] = {{(ACC_W-DATA_W){in_row[DATA_W*gi+DATA_W-1]}},
                        in_row[DATA_W*gi +: DATA_W]};
    assign row_h[gi] = xform(cur_type, 2'(gi), row_x[0], row_x[1], row_x[2], row_x[3]);
    assign out_row[DATA_W*gi +: DATA_W] = out_valid ? buf_q[idx_q][gi] : '0;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col_k
    for (genvar gj = 0; gj < 4; gj++) begin : g_col_c
      assign col_y[gi][gj] = xform(tx_q, 2'(gi),
                                   h_q[0][gj], h_q[1][gj], h_q[2][gj], h_q[3][gj]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hs) state_d = LOAD;
      LOAD:    if (in_hs && cnt_q == 2'd3) state_d = COMPUTE;
      COMPUTE: state_d = OUT;
      OUT:     if (out_hs && idx_q == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      tx_q  <= '0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          h_q[r][c]   <= '0;
          buf_q[r][c] <= '0;
        end
      end
    end else begin
      en_q <= 1'b1;
      if (in_hs) begin
        for (int c = 0; c < 4; c++) begin
          h_q[cnt_q][c] <= row_h[c];
        end
        cnt_q <= cnt_q + 2'd1;
        if (state_q == IDLE) begin
          tx_q <= tx_type;
        end
      end
      if (state_q == COMPUTE) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            buf_q[r][c] <= sat(col_y[r][c]);
          end
        end
      end
      if (out_hs) begin
        idx_q <= (idx_q == 2'd3) ? 2'd0 : idx_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_av2_forward_transform_4x4.sv
// Directed bench for av2_forward_transform_4x4 with hand-computed coefficients.
module tb_av2_forward_transform_4x4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  tx_type;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_row;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_row;
  logic [1:0]  out_row_idx;
  logic        out_last;
  logic        busy;

  int errors = 0;
  int checks = 0;

  av2_forward_transform_4x4 #(.DATA_W(16), .ACC_W(24)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_type     (tx_type),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_last    (out_last),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_row(input logic [63:0] r);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_row   = r;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic recv_row(input string tag, input int idx, input logic [63:0] exp,
                          output int waited);
    int w;
    @(negedge clk);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    waited = w;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_idx"}, 64'(out_row_idx), 64'(idx));
    chk({tag, "_last"}, 64'(out_last), 64'(idx == 3));
    chk({tag, "_data"}, out_row, exp);
    $display("row %s idx=%0d data=%h", tag, out_row_idx, out_row);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_block(input string name, input logic [1:0] tt,
                           input logic [63:0] r0, input logic [63:0] r1,
                           input logic [63:0] r2, input logic [63:0] r3,
                           input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3);
    int w;
    tx_type = tt;
    send_row(r0);
    chk({name, "_busy"}, 64'(busy), 64'd1);
    send_row(r1);
    send_row(r2);
    send_row(r3);
    @(negedge clk);
    chk({name, "_compute_novalid"}, 64'(out_valid), 64'd0);
    chk({name, "_compute_noready"}, 64'(in_ready), 64'd0);
    recv_row({name, "_r0"}, 0, e0, w);
    chk({name, "_latency"}, 64'(w), 64'd0);
    recv_row({name, "_r1"}, 1, e1, w);
    recv_row({name, "_r2"}, 2, e2, w);
    recv_row({name, "_r3"}, 3, e3, w);
    @(negedge clk);
    chk({name, "_ready_after"}, 64'(in_ready), 64'd1);
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
    chk({name, "_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_out_row"}, out_row, 64'd0);
    chk({name, "_out_idx"}, 64'(out_row_idx), 64'd0);
    chk({name, "_out_last"}, 64'(out_last), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] z;
    logic [63:0] ones;
    int w;
    z    = 64'd0;
    ones = pk(1, 1, 1, 1);
    rst_n     = 1'b0;
    tx_type   = 2'd0;
    in_valid  = 1'b0;
    in_row    = '0;
    out_ready = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'd1);

    run_block("dct_ones", 2'd0, ones, ones, ones, ones,
              pk(16, 0, 0, 0), z, z, z);
    run_block("dct_ramp", 2'd0, pk(1, 2, 3, 4), z, z, z,
              pk(10, -7, 0, -1), pk(20, -14, 0, -2), pk(10, -7, 0, -1), pk(10, -7, 0, -1));
    run_block("wht_ones", 2'd1, ones, ones, ones, ones,
              pk(16, 0, 0, 0), z, z, z);
    run_block("ident", 2'd2, pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(9, 10, 11, 12), pk(13, 14, 15, 16),
              pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(9, 10, 11, 12), pk(13, 14, 15, 16));
    run_block("reserved", 2'd3, pk(-5, 7, -9, 11), z, z, pk(-1, 0, 2, -3),
              pk(-5, 7, -9, 11), z, z, pk(-1, 0, 2, -3));
    run_block("wht_ramp", 2'd1, pk(1, 2, 3, 4), z, z, z,
              pk(10, -4, 0, -2), pk(10, -4, 0, -2), pk(10, -4, 0, -2), pk(10, -4, 0, -2));
    run_block("sat_pos", 2'd0, pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767),
              pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767),
              pk(32767, 0, 0, 0), z, z, z);
    run_block("sat_neg", 2'd0, pk(-32768, -32768, -32768, -32768), pk(-32768, -32768, -32768, -32768),
              pk(-32768, -32768, -32768, -32768), pk(-32768, -32768, -32768, -32768),
              pk(-32768, 0, 0, 0), z, z, z);

    // Backpressure on row 1; tx_type change after row 0 must be ignored.
    tx_type = 2'd0;
    send_row(pk(1, 2, 3, 4));
    tx_type = 2'd2;
    send_row(z);
    send_row(z);
    send_row(z);
    @(negedge clk);
    recv_row("bp_r0", 0, pk(10, -7, 0, -1), w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_idx", 64'(out_row_idx), 64'd1);
      chk("bp_hold_data", out_row, pk(20, -14, 0, -2));
      chk("bp_hold_noready", 64'(in_ready), 64'd0);
    end
    recv_row("bp_r1", 1, pk(20, -14, 0, -2), w);
    recv_row("bp_r2", 2, pk(10, -7, 0, -1), w);
    recv_row("bp_r3", 3, pk(10, -7, 0, -1), w);
    @(negedge clk);
    chk("bp_ready_after", 64'(in_ready), 64'd1);

    // Abort a block after two rows with an asynchronous reset.
    tx_type = 2'd0;
    send_row(pk(1000, 1000, 1000, 1000));
    send_row(pk(1000, 1000, 1000, 1000));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", 64'(in_ready), 64'd1);
    run_block("post_abort", 2'd0, ones, ones, ones, ones,
              pk(16, 0, 0, 0), z, z, z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
